// File: rtl/l2_arbiter_pkg.sv
// Shared types and default widths for the two-requester L2 arbiter.
// Requester 0 is the L1 data cache, requester 1 the L1 instruction cache.
package l2_arbiter_pkg;

    localparam int DEF_DATA_WIDTH    = 32;
    localparam int DEF_ADDR_WIDTH    = 32;
    localparam int DEF_L1_BLOCK_SIZE = 16;

    localparam logic GRANT_D = 1'b0;
    localparam logic GRANT_I = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/l2_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the one not granted last.
// req[0] is the data requester, req[1] the instruction requester.
module rr_pick2
    import l2_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant
);

    always_comb begin
        grant = GRANT_D;
        case (req)
            2'b10:   grant = GRANT_I;
            2'b11:   grant = ~last;
            default: grant = GRANT_D;
        endcase
    end

endmodule

// File: rtl/l2_arbiter.sv
// Arbitrates L1 data and instruction block requests onto a single L2 port.
// One transaction at a time: IDLE picks a winner, WAIT holds the L2 strobe, RESP pulses ready.
module l2_arbiter
    import l2_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int L1_BLOCK_SIZE  = DEF_L1_BLOCK_SIZE,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [ADDR_WIDTH-1:0]                l1d_addr,
    input  logic [L1_BLOCK_SIZE*DATA_WIDTH-1:0]  l1d_wdata,
    input  logic                                 l1d_read,
    input  logic                                 l1d_write,
    output logic [L1_BLOCK_SIZE*DATA_WIDTH-1:0]  l1d_rdata,
    output logic                                 l1d_ready,
    input  logic [ADDR_WIDTH-1:0]                l1i_addr,
    input  logic [L1_BLOCK_SIZE*DATA_WIDTH-1:0]  l1i_wdata,
    input  logic                                 l1i_read,
    input  logic                                 l1i_write,
    output logic [L1_BLOCK_SIZE*DATA_WIDTH-1:0]  l1i_rdata,
    output logic                                 l1i_ready,
    output logic [ADDR_WIDTH-1:0]                l2_cache_addr,
    output logic [L1_BLOCK_SIZE*DATA_WIDTH-1:0]  l2_cache_data_in,
    input  logic [L1_BLOCK_SIZE*DATA_WIDTH-1:0]  l2_cache_data_out,
    output logic                                 l2_cache_read,
    output logic                                 l2_cache_write,
    input  logic                                 l2_cache_ready,
    output logic                                 grant_id,
    output logic                                 busy,
    output logic                                 err_timeout
);

    localparam int BLK_W = L1_BLOCK_SIZE * DATA_WIDTH;
    // A zero limit disables the timeout; keep the counter one bit wide so it still elaborates.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    state_t           state;
    logic             last_grant;
    logic [CNT_W-1:0] wait_cnt;

    logic                  req_d;
    logic                  req_i;
    logic                  pick;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [BLK_W-1:0]      sel_wdata;
    logic                  sel_read;
    logic                  sel_write;
    logic                  timed_out;

    assign req_d = l1d_read | l1d_write;
    assign req_i = l1i_read | l1i_write;

    rr_pick2 u_pick (
        .req   ({req_i, req_d}),
        .last  (last_grant),
        .grant (pick)
    );

    always_comb begin
        sel_addr  = l1d_addr;
        sel_wdata = l1d_wdata;
        sel_read  = l1d_read;
        sel_write = l1d_write;
        if (pick == GRANT_I) begin
            sel_addr  = l1i_addr;
            sel_wdata = l1i_wdata;
            sel_read  = l1i_read;
            sel_write = l1i_write;
        end
    end

    assign timed_out = (TIMEOUT_CYCLES > 0) && (wait_cnt == CNT_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_IDLE;
            last_grant       <= GRANT_I;
            wait_cnt         <= '0;
            grant_id         <= GRANT_D;
            busy             <= 1'b0;
            err_timeout      <= 1'b0;
            l1d_ready        <= 1'b0;
            l1i_ready        <= 1'b0;
            l1d_rdata        <= '0;
            l1i_rdata        <= '0;
            l2_cache_addr    <= '0;
            l2_cache_data_in <= '0;
            l2_cache_read    <= 1'b0;
            l2_cache_write   <= 1'b0;
        end else begin
            l1d_ready   <= 1'b0;
            l1i_ready   <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_d | req_i) begin
                        grant_id         <= pick;
                        busy             <= 1'b1;
                        wait_cnt         <= '0;
                        l2_cache_addr    <= sel_addr;
                        l2_cache_data_in <= sel_wdata;
                        // A simultaneous read and write is forwarded as a write.
                        l2_cache_write   <= sel_write;
                        l2_cache_read    <= sel_read & ~sel_write;
                        state            <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (l2_cache_ready) begin
                        l2_cache_read  <= 1'b0;
                        l2_cache_write <= 1'b0;
                        if (grant_id == GRANT_I) begin
                            l1i_rdata <= l2_cache_data_out;
                            l1i_ready <= 1'b1;
                        end else begin
                            l1d_rdata <= l2_cache_data_out;
                            l1d_ready <= 1'b1;
                        end
                        state <= ST_RESP;
                    end else if (timed_out) begin
                        l2_cache_read  <= 1'b0;
                        l2_cache_write <= 1'b0;
                        err_timeout    <= 1'b1;
                        if (grant_id == GRANT_I) begin
                            l1i_rdata <= '0;
                            l1i_ready <= 1'b1;
                        end else begin
                            l1d_rdata <= '0;
                            l1d_ready <= 1'b1;
                        end
                        state <= ST_RESP;
                    end else if (wait_cnt != CNT_LIMIT) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    busy       <= 1'b0;
                    last_grant <= grant_id;
                    state      <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l2_arbiter.sv
// Scoreboard bench for l2_arbiter: a behavioural L2 with programmable latency,
// level-holding L1 requesters, and per-scenario tasks with inline checks.
module tb_l2_arbiter;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int BS  = 16;
    localparam int TO  = 8;
    localparam int BLK = DW * BS;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [AW-1:0]  l1d_addr = '0, l1i_addr = '0;
    logic [BLK-1:0] l1d_wdata = '0, l1i_wdata = '0;
    logic           l1d_read = 1'b0, l1d_write = 1'b0, l1i_read = 1'b0, l1i_write = 1'b0;
    logic [BLK-1:0] l1d_rdata, l1i_rdata;
    logic           l1d_ready, l1i_ready;
    logic [AW-1:0]  l2_cache_addr;
    logic [BLK-1:0] l2_cache_data_in;
    logic [BLK-1:0] l2_cache_data_out = '0;
    logic           l2_cache_read, l2_cache_write;
    logic           l2_cache_ready = 1'b0;
    logic           grant_id, busy, err_timeout;

    int total = 0;
    int bad   = 0;
    int l2_delay = 0;
    int d_pend = 0;
    int i_pend = 0;
    logic [BLK-1:0] shadow_d = '0;
    logic [BLK-1:0] shadow_i = '0;

    typedef struct {
        logic           id;
        logic [BLK-1:0] rdata;
        logic           err;
    } exp_t;
    exp_t sb[$];

    l2_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .L1_BLOCK_SIZE(BS), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .l1d_addr(l1d_addr), .l1d_wdata(l1d_wdata), .l1d_read(l1d_read), .l1d_write(l1d_write),
        .l1d_rdata(l1d_rdata), .l1d_ready(l1d_ready),
        .l1i_addr(l1i_addr), .l1i_wdata(l1i_wdata), .l1i_read(l1i_read), .l1i_write(l1i_write),
        .l1i_rdata(l1i_rdata), .l1i_ready(l1i_ready),
        .l2_cache_addr(l2_cache_addr), .l2_cache_data_in(l2_cache_data_in),
        .l2_cache_data_out(l2_cache_data_out), .l2_cache_read(l2_cache_read),
        .l2_cache_write(l2_cache_write), .l2_cache_ready(l2_cache_ready),
        .grant_id(grant_id), .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [BLK-1:0] l2_block(input logic [AW-1:0] a);
        logic [BLK-1:0] r;
        for (int k = 0; k < BS; k++)
            r[k*DW +: DW] = (k == 0) ? (32'hA5 ^ (a - 32'h100)) : (a + k * 32'h01010101);
        return r;
    endfunction

    function automatic exp_t mk_exp(input logic id, input logic [BLK-1:0] rd, input logic err);
        exp_t e;
        e.id = id;
        e.rdata = rd;
        e.err = err;
        return e;
    endfunction

    // Behavioural L2: answers l2_delay cycles after the strobe appears; 0 means never.
    initial begin
        int scnt;
        scnt = 0;
        forever begin
            @(negedge clk);
            l2_cache_ready = 1'b0;
            if (l2_cache_read || l2_cache_write) begin
                scnt++;
                if (l2_delay > 0 && scnt == l2_delay) begin
                    l2_cache_ready = 1'b1;
                    l2_cache_data_out = l2_block(l2_cache_addr);
                end
            end else begin
                scnt = 0;
            end
        end
    end

    // Requesters keep their level until the last pending transaction is acknowledged.
    initial forever begin
        @(negedge clk);
        if (l1d_ready) begin
            if (d_pend > 0) d_pend--;
            if (d_pend == 0) begin l1d_read = 1'b0; l1d_write = 1'b0; end
        end
    end
    initial forever begin
        @(negedge clk);
        if (l1i_ready) begin
            if (i_pend > 0) i_pend--;
            if (i_pend == 0) begin l1i_read = 1'b0; l1i_write = 1'b0; end
        end
    end

    // Scoreboard pop on every ready pulse, plus the no-strobe-outside-a-transaction rule.
    always @(negedge clk) begin
        if (!rst) begin
            if (!busy && (l2_cache_read || l2_cache_write)) begin
                total++; bad++;
                $display("FAIL strobe_idle got rd=%0b wr=%0b want 0 0", l2_cache_read, l2_cache_write);
            end
            if (err_timeout && !(l1d_ready || l1i_ready)) begin
                total++; bad++;
                $display("FAIL err_alone got err=1 without ready want err=0");
            end
            if (l1d_ready || l1i_ready) begin
                total++;
                if (l1d_ready && l1i_ready) begin
                    bad++;
                    $display("FAIL both_ready got d=1 i=1 want one");
                end else if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_ready got d=%0b i=%0b want none", l1d_ready, l1i_ready);
                end else begin
                    exp_t e;
                    logic [BLK-1:0] rd, other, other_exp;
                    e = sb.pop_front();
                    rd        = l1i_ready ? l1i_rdata : l1d_rdata;
                    other     = l1i_ready ? l1d_rdata : l1i_rdata;
                    other_exp = l1i_ready ? shadow_d : shadow_i;
                    if (l1i_ready !== e.id || rd !== e.rdata || err_timeout !== e.err || other !== other_exp) begin
                        bad++;
                        $display("FAIL sb_resp got id=%0b w0=%h err=%0b other_w0=%h want id=%0b w0=%h err=%0b other_w0=%h",
                                 l1i_ready, rd[31:0], err_timeout, other[31:0],
                                 e.id, e.rdata[31:0], e.err, other_exp[31:0]);
                    end
                    if (e.id) shadow_i = e.rdata; else shadow_d = e.rdata;
                end
            end
        end
    end

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if ({l2_cache_read, l2_cache_write, l1d_ready, l1i_ready, busy, err_timeout, grant_id} !== 7'b0) begin
            bad++;
            $display("FAIL reset_ctrl got %b want 0000000",
                     {l2_cache_read, l2_cache_write, l1d_ready, l1i_ready, busy, err_timeout, grant_id});
        end
        total++;
        if (l2_cache_addr !== '0 || l2_cache_data_in !== '0 || l1d_rdata !== '0 || l1i_rdata !== '0) begin
            bad++;
            $display("FAIL reset_data got addr=%h din0=%h d0=%h i0=%h want 0", l2_cache_addr,
                     l2_cache_data_in[31:0], l1d_rdata[31:0], l1i_rdata[31:0]);
        end
        rst = 1'b0;
    endtask

    // Runs until the scoreboard is empty and the arbiter idle; records strobe rises and grants.
    task automatic run_until_drained(output int rises, output logic [3:0] grants,
                                     output int first_rise, output int second_rise,
                                     output int d_rdy, output int i_rdy, output logic done);
        logic prev, st;
        prev = 1'b0; rises = 0; grants = '0; first_rise = -1; second_rise = -1;
        d_rdy = -1; i_rdy = -1; done = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            st = l2_cache_read | l2_cache_write;
            if (st && !prev) begin
                if (rises < 4) grants[rises] = grant_id;
                if (rises == 0) first_rise = k;
                if (rises == 1) second_rise = k;
                rises++;
            end
            prev = st;
            if (l1d_ready && d_rdy < 0) d_rdy = k;
            if (l1i_ready && i_rdy < 0) i_rdy = k;
            if (sb.size() == 0 && !busy) begin done = 1'b1; break; end
        end
    endtask

    task automatic test_tie();
        int rises, r1, r2, dr, ir;
        logic [3:0] g;
        logic done;
        @(negedge clk);
        l2_delay = 3;
        l1d_addr = 32'h200; l1i_addr = 32'h300;
        d_pend = 1; i_pend = 1;
        l1d_read = 1'b1; l1i_read = 1'b1;
        sb.push_back(mk_exp(1'b0, l2_block(32'h200), 1'b0));
        sb.push_back(mk_exp(1'b1, l2_block(32'h300), 1'b0));
        run_until_drained(rises, g, r1, r2, dr, ir, done);
        total++;
        if (!done || rises !== 2 || g[1:0] !== 2'b10) begin
            bad++;
            $display("FAIL tie_order got done=%0b rises=%0d grants=%b want 1 2 grants=10", done, rises, g[1:0]);
        end
        total++;
        if (r2 !== dr + 2) begin
            bad++;
            $display("FAIL tie_i_strobe got cycle=%0d want %0d", r2, dr + 2);
        end
    endtask

    task automatic test_back_to_back();
        int rises, r1, r2, dr, ir;
        logic [3:0] g;
        logic done;
        @(negedge clk);
        l2_delay = 2;
        l1d_addr = 32'h400; l1i_addr = 32'h500;
        d_pend = 2; i_pend = 2;
        l1d_read = 1'b1; l1i_read = 1'b1;
        for (int n = 0; n < 2; n++) begin
            sb.push_back(mk_exp(1'b0, l2_block(32'h400), 1'b0));
            sb.push_back(mk_exp(1'b1, l2_block(32'h500), 1'b0));
        end
        run_until_drained(rises, g, r1, r2, dr, ir, done);
        total++;
        if (!done || rises !== 4 || g !== 4'b1010) begin
            bad++;
            $display("FAIL b2b_alternate got done=%0b rises=%0d grants(3..0)=%b want 1 4 1010", done, rises, g);
        end
    endtask

    task automatic test_lone_read();
        int s, r;
        logic steady, done;
        @(negedge clk);
        l2_delay = 6;
        l1d_addr = 32'h100;
        d_pend = 1;
        l1d_read = 1'b1;
        sb.push_back(mk_exp(1'b0, l2_block(32'h100), 1'b0));
        s = -1; r = -1; steady = 1'b1; done = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (s < 0 && (l2_cache_read || l2_cache_write)) begin
                s = k;
                total++;
                if (l2_cache_addr !== 32'h100 || l2_cache_read !== 1'b1 || l2_cache_write !== 1'b0 || grant_id !== 1'b0) begin
                    bad++;
                    $display("FAIL lone_strobe got addr=%h rd=%0b wr=%0b gid=%0b want 100 1 0 0",
                             l2_cache_addr, l2_cache_read, l2_cache_write, grant_id);
                end
            end else if (s >= 0 && r < 0 && !l1d_ready) begin
                if (l2_cache_addr !== 32'h100 || l2_cache_read !== 1'b1 || l2_cache_write !== 1'b0) steady = 1'b0;
            end
            if (l1d_ready && r < 0) r = k;
            if (sb.size() == 0 && !busy) begin done = 1'b1; break; end
        end
        total++;
        if (!done || r - s !== 6) begin
            bad++;
            $display("FAIL lone_latency got done=%0b cycles=%0d want 1 6", done, r - s);
        end
        total++;
        if (!steady) begin
            bad++;
            $display("FAIL wait_steady got changed want constant strobe/addr");
        end
    endtask

    task automatic test_rw_both();
        int rises, r1, r2, dr, ir;
        logic [3:0] g;
        logic done, seen;
        logic [BLK-1:0] wd;
        for (int k = 0; k < BS; k++) wd[k*DW +: DW] = $urandom;
        @(negedge clk);
        l2_delay = 2;
        l1d_addr = 32'h600; l1d_wdata = wd;
        d_pend = 1;
        l1d_read = 1'b1; l1d_write = 1'b1;
        sb.push_back(mk_exp(1'b0, l2_block(32'h600), 1'b0));
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            if (l2_cache_read || l2_cache_write) begin
                seen = 1'b1;
                total++;
                if (l2_cache_write !== 1'b1 || l2_cache_read !== 1'b0 || l2_cache_data_in !== wd || l2_cache_addr !== 32'h600) begin
                    bad++;
                    $display("FAIL rw_as_write got wr=%0b rd=%0b din0=%h addr=%h want 1 0 %h 600",
                             l2_cache_write, l2_cache_read, l2_cache_data_in[31:0], l2_cache_addr, wd[31:0]);
                end
            end
        end
        run_until_drained(rises, g, r1, r2, dr, ir, done);
        total++;
        if (!seen || !done) begin
            bad++;
            $display("FAIL rw_complete got seen=%0b done=%0b want 1 1", seen, done);
        end
    endtask

    task automatic test_timeout();
        int s, r;
        logic done, busy_after;
        @(negedge clk);
        l2_delay = 0;
        l1i_addr = 32'h700;
        i_pend = 1;
        l1i_read = 1'b1;
        sb.push_back(mk_exp(1'b1, '0, 1'b1));
        s = -1; r = -1; done = 1'b0; busy_after = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (s < 0 && (l2_cache_read || l2_cache_write)) s = k;
            if (r >= 0 && k == r + 1) busy_after = busy;
            if (l1i_ready && r < 0) r = k;
            if (sb.size() == 0 && !busy) begin done = 1'b1; break; end
        end
        total++;
        if (!done || r - s !== 9) begin
            bad++;
            $display("FAIL timeout_latency got done=%0b cycles=%0d want 1 9", done, r - s);
        end
        total++;
        if (busy_after !== 1'b0) begin
            bad++;
            $display("FAIL timeout_busy got %0b want 0", busy_after);
        end
    endtask

    task automatic test_reset_mid();
        int rises, r1, r2, dr, ir, s;
        logic [3:0] g;
        logic done;
        @(negedge clk);
        l2_delay = 20;
        l1d_addr = 32'h800;
        d_pend = 1;
        l1d_read = 1'b1;
        sb.push_back(mk_exp(1'b0, l2_block(32'h800), 1'b0));
        s = -1;
        for (int k = 0; k < 50 && s < 0; k++) begin
            @(negedge clk);
            if (l2_cache_read || l2_cache_write) s = k;
        end
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if (s < 0 || {l2_cache_read, l2_cache_write, l1d_ready, l1i_ready, busy, err_timeout, grant_id} !== 7'b0) begin
            bad++;
            $display("FAIL rstmid_ctrl got strobe_seen=%0d ctrl=%b want >=0 0000000", s,
                     {l2_cache_read, l2_cache_write, l1d_ready, l1i_ready, busy, err_timeout, grant_id});
        end
        total++;
        if (l2_cache_addr !== '0 || l2_cache_data_in !== '0 || l1d_rdata !== '0 || l1i_rdata !== '0) begin
            bad++;
            $display("FAIL rstmid_data got addr=%h d0=%h i0=%h want 0", l2_cache_addr, l1d_rdata[31:0], l1i_rdata[31:0]);
        end
        sb.delete();
        shadow_d = '0; shadow_i = '0;
        d_pend = 0; l1d_read = 1'b0;
        repeat (2) begin
            @(negedge clk);
            total++;
            if (l1d_ready !== 1'b0 || l1i_ready !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL rstmid_hold got d=%0b i=%0b busy=%0b want 0 0 0", l1d_ready, l1i_ready, busy);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        l2_delay = 4;
        l1d_addr = 32'h900; l1i_addr = 32'hA00;
        d_pend = 1; i_pend = 1;
        l1d_read = 1'b1; l1i_read = 1'b1;
        sb.push_back(mk_exp(1'b0, l2_block(32'h900), 1'b0));
        sb.push_back(mk_exp(1'b1, l2_block(32'hA00), 1'b0));
        run_until_drained(rises, g, r1, r2, dr, ir, done);
        total++;
        if (!done || rises !== 2 || g[1:0] !== 2'b10) begin
            bad++;
            $display("FAIL rstmid_fresh got done=%0b rises=%0d grants=%b want 1 2 10", done, rises, g[1:0]);
        end
    endtask

    initial begin
        test_reset();
        test_tie();
        test_back_to_back();
        test_lone_read();
        test_rw_both();
        test_timeout();
        test_reset_mid();
        repeat (3) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL leftover got %0d want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
